snap_capture_ctrl: RTL and testbench

SNAP_CAPTURE_CTRL -- requirements
Module: snap_capture_ctrl

---
 rtl/snap_pkg.sv | 19 +
 rtl/snap_capture_ctrl.sv | 135 +++++++++++++
 tb/tb_snap_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snap_pkg.sv
// Shared definitions for the snapshot capture controller: FSM states,
// software control-word bit positions and status-word bit positions.
package snap_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } snap_state_e;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_TRIG_SRC = 1;

  localparam int ST_DONE  = 31;
  localparam int ST_BUSY  = 30;
  localparam int ST_ARMED = 29;

endpackage

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arms on an enable rising edge, optionally waits
// for a trigger, then streams 2^ADDR_WIDTH samples into a BRAM write port.
// Optional macro SNAP_TIMESTAMP_EN adds a free-running cycle counter latched at trigger.
module snap_capture_ctrl
  import snap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  user_clk,
  input  logic                  user_rst_n,
  input  logic [31:0]           ctrl,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  input  logic                  trig,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic                  bram_we,
  output logic [31:0]           status,
  output logic [31:0]           tstamp
);

  // din/trig carry meaning only on cycles with din_vld=1; there is no
  // backpressure, every valid sample seen in CAPTURE is written one cycle later.
  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  snap_state_e           state_q, state_d;
  logic                  en_q;
  logic [ADDR_WIDTH:0]   count_q, count_d, count_inc;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_data_q, bram_data_d;
  logic                  bram_we_q, bram_we_d;
  logic [31:0]           status_q, status_d;
  logic                  en_rise;
  logic                  ctrl_unused;

  assign ctrl_unused = ^ctrl[31:2];
  assign en_rise     = ctrl[CTRL_EN] & ~en_q;
  assign count_inc   = count_q + ONE;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    bram_we_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (en_rise) begin
          state_d = S_ARMED;
          count_d = '0;
        end
      end
      S_ARMED: begin
        if (!ctrl[CTRL_EN]) begin
          state_d = S_IDLE;
        end else if (!ctrl[CTRL_TRIG_SRC]) begin
          state_d = S_CAPTURE;
        end else if (din_vld && trig) begin
          // The triggering sample itself lands at address 0.
          bram_we_d   = 1'b1;
          bram_addr_d = '0;
          bram_data_d = din;
          count_d     = ONE;
          state_d     = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!ctrl[CTRL_EN]) begin
          state_d = S_IDLE;
        end else if (din_vld) begin
          bram_we_d   = 1'b1;
          bram_addr_d = count_q[ADDR_WIDTH-1:0];
          bram_data_d = din;
          count_d     = count_inc;
          if (count_inc == FULL) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    status_d                 = '0;
    status_d[ST_DONE]        = (state_d == S_DONE);
    status_d[ST_BUSY]        = (state_d == S_CAPTURE);
    status_d[ST_ARMED]       = (state_d == S_ARMED);
    status_d[ADDR_WIDTH:0]   = count_d;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      count_q     <= '0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= ctrl[CTRL_EN];
      count_q     <= count_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_we_q   <= bram_we_d;
      status_q    <= status_d;
    end
  end

  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign bram_we   = bram_we_q;
  assign status    = status_q;

`ifdef SNAP_TIMESTAMP_EN
  logic [31:0] cyc_q, tstamp_q;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cyc_q    <= '0;
      tstamp_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (state_q == S_ARMED && state_d == S_CAPTURE) tstamp_q <= cyc_q;
    end
  end

  assign tstamp = tstamp_q;
`else
  assign tstamp = '0;
`endif

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Self-checking bench for snap_capture_ctrl (ADDR_WIDTH=4): a cycle table for
// state/status sequencing plus directed capture, abort, reset and timestamp runs.
module tb_snap_capture_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int SBW = AW + DW;

  logic           user_clk   = 1'b0;
  logic           user_rst_n = 1'b0;
  logic [31:0]    ctrl       = '0;
  logic [DW-1:0]  din        = '0;
  logic           din_vld    = 1'b0;
  logic           trig       = 1'b0;
  logic [AW-1:0]  bram_addr;
  logic [DW-1:0]  bram_data;
  logic           bram_we;
  logic [31:0]    status;
  logic [31:0]    tstamp;

  int total = 0;
  int bad   = 0;
  logic [SBW-1:0] exp_q[$];

  typedef struct {
    logic          en;
    logic          src;
    logic          vld;
    logic          tg;
    logic [DW-1:0] d;
    logic [31:0]   st;
    logic          we;
    logic [AW-1:0] a;
  } vec_t;

  vec_t tbl[13];

  // clock / reset
  always #5 user_clk = ~user_clk;

  snap_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl       (ctrl),
    .din        (din),
    .din_vld    (din_vld),
    .trig       (trig),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_we    (bram_we),
    .status     (status),
    .tstamp     (tstamp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic drive(input logic en, input logic src, input logic vld,
                       input logic tg, input logic [DW-1:0] d);
    ctrl    = {30'd0, src, en};
    din_vld = vld;
    trig    = tg;
    din     = d;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    user_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(2);
    user_rst_n = 1'b1;
  endtask

  task automatic chk_drain(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // scoreboard: every observed write must match the head of the expected queue
  always @(negedge user_clk) begin
    logic [SBW-1:0] e_v;
    if (user_rst_n && bram_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                 bram_addr, bram_data);
      end else begin
        e_v = exp_q.pop_front();
        chk("wr_addr", 32'(bram_addr), 32'(e_v[SBW-1:DW]));
        chk("wr_data", bram_data, e_v[DW-1:0]);
      end
    end
  end

  initial begin
    logic en_v;
    logic v;
    int   n;

    //            en    src   vld   tg    din          status        we    addr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0000_0000, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h2000_0000, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hA1, 32'h2000_0000, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA3, 32'h2000_0000, 1'b0, 4'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hA4, 32'h4000_0001, 1'b1, 4'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hA5, 32'h4000_0002, 1'b1, 4'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hA6, 32'h4000_0002, 1'b0, 4'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hA7, 32'h0000_0002, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hA8, 32'h0000_0002, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA9, 32'h2000_0000, 1'b0, 4'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hAA, 32'h4000_0000, 1'b0, 4'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hAB, 32'h4000_0001, 1'b1, 4'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hAC, 32'h0000_0001, 1'b0, 4'd0};

    // reset state
    do_reset();
    chk("rst_status", status, 32'h0);
    chk("rst_we", 32'(bram_we), 32'h0);
    chk("rst_addr", 32'(bram_addr), 32'h0);
    chk("rst_data", bram_data, 32'h0);
    chk("rst_tstamp", tstamp, 32'h0);

    // cycle table: arm, trigger, abort, immediate re-arm
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].en, tbl[i].src, tbl[i].vld, tbl[i].tg, tbl[i].d);
      if (tbl[i].we) expect_wr(tbl[i].a, tbl[i].d);
      step(1);
      chk($sformatf("tbl%0d_status", i), status, tbl[i].st);
      chk($sformatf("tbl%0d_we", i), 32'(bram_we), 32'(tbl[i].we));
    end
    chk_drain("tbl_drain");

    // full-depth immediate capture, din = counter
    do_reset();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, DW'(i));
      if (i >= 2 && i < 18) expect_wr(AW'(i - 2), DW'(i));
      step(1);
      if (i == 1) chk("full_busy", status, 32'h4000_0000);
    end
    chk("full_status", status, 32'h8000_0010);
    chk("full_we_idle", 32'(bram_we), 32'h0);
    chk_drain("full_drain");

    // external trigger on the 5th valid sample
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b1, i > 0, i == 5, DW'(i));
      if (i >= 5) expect_wr(AW'(i - 5), DW'(i));
      step(1);
      if (i == 4) chk("trig_armed", status, 32'h2000_0000);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1);
    chk("trig_abort_status", status, 32'h0000_0008);
    chk_drain("trig_drain");

    // din_vld toggling during capture
    do_reset();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      v = (i % 2 == 0);
      drive(1'b1, 1'b0, v, 1'b0, DW'(100 + i));
      if (i >= 2 && v && n < 16) begin
        expect_wr(AW'(n), DW'(100 + i));
        n++;
      end
      step(1);
    end
    chk("toggle_status", status, 32'h8000_0010);
    chk_drain("toggle_drain");

    // abort after 7 writes, then re-enable
    do_reset();
    for (int i = 0; i < 15; i++) begin
      en_v = (i != 9);
      drive(en_v, 1'b0, 1'b1, 1'b0, DW'(200 + i));
      if (i >= 2 && i < 9) expect_wr(AW'(i - 2), DW'(200 + i));
      if (i >= 12) expect_wr(AW'(i - 12), DW'(200 + i));
      step(1);
      if (i == 9) chk("abort_status", status, 32'h0000_0007);
      if (i == 10) chk("rearm_status", status, 32'h2000_0000);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1);
    chk("restart_status", status, 32'h0000_0003);
    chk_drain("abort_drain");

    // reset asserted mid-capture
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, i < 5, 1'b0, DW'(300 + i));
      if (i >= 2 && i < 5) expect_wr(AW'(i - 2), DW'(300 + i));
      step(1);
    end
    chk("pre_rst_status", status, 32'h4000_0003);
    chk("pre_rst_addr", 32'(bram_addr), 32'd2);
    user_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    chk("midrst_status", status, 32'h0);
    chk("midrst_addr", 32'(bram_addr), 32'h0);
    chk("midrst_data", bram_data, 32'h0);
    chk("midrst_we", 32'(bram_we), 32'h0);
    chk("midrst_tstamp", tstamp, 32'h0);
    step(1);
    user_rst_n = 1'b1;
    step(3);
    chk("post_rst_status", status, 32'h0);
    chk("post_rst_we", 32'(bram_we), 32'h0);
    chk_drain("rst_drain");

    // timestamp: ARMED->CAPTURE on the 101st edge after reset release
    do_reset();
    step(99);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(2);
    chk("ts_busy", status, 32'h4000_0000);
`ifdef SNAP_TIMESTAMP_EN
    chk("tstamp", tstamp, 32'd100);
`else
    chk("tstamp", tstamp, 32'd0);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(2);
    chk_drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
